// File: rtl/hms_time_core.sv
// hms_time_core: hour:minute:second timekeeping core with debounced buttons,
// a CLOCK/SETUP mode, and a selectable 12/24-hour format. Everything runs on
// clk; seconds advance on a clock enable produced by a free-running divider.

module hms_time_core #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned DB_CYCLES = 500_000,
    parameter bit          H24       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw_mode,
    input  logic       i_sw_pos,
    input  logic       i_sw_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_pm,
    output logic       o_mode,
    output logic [1:0] o_pos,
    output logic       o_tick,
    output logic       o_blink
);

    localparam int unsigned TW = $clog2(CLK_HZ);
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_HZ - 1);
    localparam logic [TW-1:0] BLINK_HALF = TW'(CLK_HZ / 2);
    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
    localparam logic [4:0]    HOUR_RST   = H24 ? 5'd0 : 5'd12;

    typedef enum logic {
        MODE_CLOCK = 1'b0,
        MODE_SETUP = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_e;

    // Button bit order everywhere: [0] mode, [1] pos, [2] inc.
    logic [2:0]         btn_raw;
    logic [2:0]         sync1_q, sync1_d;
    logic [2:0]         sync2_q, sync2_d;
    logic [2:0]         level_q, level_d;
    logic [2:0]         press_q, press_d;
    logic [2:0][CW-1:0] db_cnt_q, db_cnt_d;

    logic          press_mode, press_pos, press_inc;
    logic          tick_last;

    mode_e         mode_q, mode_d;
    pos_e          pos_q, pos_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic          pm_q, pm_d;
    logic          tick_q, tick_d;
    logic          blink_q, blink_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;

    function automatic logic [5:0] next_sixty(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    // 24h wraps 23 -> 0; 12h runs 12 -> 1 -> ... -> 11 -> 12.
    function automatic logic [4:0] next_hour(input logic [4:0] h);
        if (H24) begin
            return (h == 5'd23) ? 5'd0 : h + 5'd1;
        end
        return (h == 5'd12) ? 5'd1 : h + 5'd1;
    endfunction

    function automatic pos_e next_pos(input pos_e p);
        case (p)
            POS_SEC: return POS_MIN;
            POS_MIN: return POS_HOUR;
            default: return POS_SEC;
        endcase
    endfunction

    assign btn_raw    = {i_sw_inc, i_sw_pos, i_sw_mode};
    assign press_mode = press_q[0];
    assign press_pos  = press_q[1];
    assign press_inc  = press_q[2];
    assign tick_last  = (tick_cnt_q == TICK_LAST);

    // Synchronise each button, accept a new level after DB_CYCLES agreeing samples, pulse on press.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        level_d  = level_q;
        press_d  = '0;
        db_cnt_d = '0;
        for (int b = 0; b < 3; b++) begin
            if (sync2_q[b] != level_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    level_d[b] = sync2_q[b];
                    press_d[b] = ~sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + CW'(1);
                end
            end
        end
    end

    // Next time, mode, field select, second divider and blink gate; a mode press overrides everything else.
    always_comb begin
        mode_d     = mode_q;
        pos_d      = pos_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        pm_d       = pm_q;
        tick_d     = tick_last && !press_mode;
        tick_cnt_d = tick_last ? '0 : tick_cnt_q + TW'(1);

        if (press_mode) begin
            tick_cnt_d = '0;
            if (mode_q == MODE_CLOCK) begin
                mode_d = MODE_SETUP;
                pos_d  = POS_SEC;
            end else begin
                mode_d = MODE_CLOCK;
            end
        end else if (mode_q == MODE_CLOCK) begin
            if (tick_last) begin
                sec_d = next_sixty(sec_q);
                if (sec_q == 6'd59) begin
                    min_d = next_sixty(min_q);
                    if (min_q == 6'd59) begin
                        hour_d = next_hour(hour_q);
                        if (!H24 && hour_q == 5'd11) begin
                            pm_d = ~pm_q;
                        end
                    end
                end
            end
        end else begin
            if (press_inc) begin
                case (pos_q)
                    POS_SEC: sec_d = next_sixty(sec_q);
                    POS_MIN: min_d = next_sixty(min_q);
                    default: begin
                        hour_d = next_hour(hour_q);
                        if (!H24 && hour_q == 5'd11) begin
                            pm_d = ~pm_q;
                        end
                    end
                endcase
            end
            if (press_pos) begin
                pos_d = next_pos(pos_q);
            end
        end

        blink_d = (mode_d == MODE_SETUP) && (tick_cnt_d < BLINK_HALF);
    end

    // All state registers; buttons reset to the released (high) level so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            level_q    <= '1;
            press_q    <= '0;
            db_cnt_q   <= '0;
            mode_q     <= MODE_CLOCK;
            pos_q      <= POS_SEC;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hour_q     <= HOUR_RST;
            pm_q       <= 1'b0;
            tick_q     <= 1'b0;
            blink_q    <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            press_q    <= press_d;
            db_cnt_q   <= db_cnt_d;
            mode_q     <= mode_d;
            pos_q      <= pos_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            pm_q       <= pm_d;
            tick_q     <= tick_d;
            blink_q    <= blink_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign o_sec   = sec_q;
    assign o_min   = min_q;
    assign o_hour  = hour_q;
    assign o_pm    = pm_q;
    assign o_mode  = mode_q;
    assign o_pos   = pos_q;
    assign o_tick  = tick_q;
    assign o_blink = blink_q;

endmodule

// File: tb/tb_hms_time_core.sv
// tb_hms_time_core: drives a 24-hour and a 12-hour instance with the same
// buttons, tracks time as seconds-of-day in a behavioural model, and compares
// both instances every cycle, plus hand-computed checkpoints.

module tb_hms_time_core;

    localparam int CLK_HZ = 10;
    localparam int DB     = 4;

    localparam logic [2:0] BTN_MODE = 3'b001;
    localparam logic [2:0] BTN_POS  = 3'b010;
    localparam logic [2:0] BTN_INC  = 3'b100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw_mode = 1'b1;
    logic sw_pos = 1'b1;
    logic sw_inc = 1'b1;

    logic [5:0] a_sec, a_min, b_sec, b_min;
    logic [4:0] a_hour, b_hour;
    logic       a_pm, a_mode, a_tick, a_blink, b_pm, b_mode, b_tick, b_blink;
    logic [1:0] a_pos, b_pos;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic rst_at_edge = 1'b0;

    // model state: time as seconds of day, plus mode/field/phase and button acceptance
    int m_t, m_mode, m_pos, m_phase, m_tick, m_blink;
    int m_acc [3];
    int m_pulse [3];
    int hist [3][16];

    bit rec_ticks = 1'b0;
    int tick_cycles [$];
    int rel_cyc;

    hms_time_core #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB), .H24(1'b1)) dut24 (
        .clk(clk), .rst_n(rst_n),
        .i_sw_mode(sw_mode), .i_sw_pos(sw_pos), .i_sw_inc(sw_inc),
        .o_sec(a_sec), .o_min(a_min), .o_hour(a_hour), .o_pm(a_pm),
        .o_mode(a_mode), .o_pos(a_pos), .o_tick(a_tick), .o_blink(a_blink)
    );

    hms_time_core #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB), .H24(1'b0)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .i_sw_mode(sw_mode), .i_sw_pos(sw_pos), .i_sw_inc(sw_inc),
        .o_sec(b_sec), .o_min(b_min), .o_hour(b_hour), .o_pm(b_pm),
        .o_mode(b_mode), .o_pos(b_pos), .o_tick(b_tick), .o_blink(b_blink)
    );

    always #5 clk = ~clk;

    // cycle counter and the reset level seen by each active edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive the masked buttons low for low_cyc cycles, then high for high_cyc cycles.
    // Called and returns at 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [2:0] mask, input int low_cyc, input int high_cyc);
        if (mask[0]) sw_mode = 1'b0;
        if (mask[1]) sw_pos = 1'b0;
        if (mask[2]) sw_inc = 1'b0;
        repeat (low_cyc) @(posedge clk);
        if (low_cyc > 0) #1;
        if (mask[0]) sw_mode = 1'b1;
        if (mask[1]) sw_pos = 1'b1;
        if (mask[2]) sw_inc = 1'b1;
        repeat (high_cyc) @(posedge clk);
        if (high_cyc > 0) #1;
    endtask

    // behavioural model advanced once per cycle, then both instances compared against it
    always @(negedge clk) begin : model_cmp
        int s, mi, h, h12, all_diff;
        int pins [3];
        logic [22:0] exp_v, got_v;

        pins[0] = int'(sw_mode);
        pins[1] = int'(sw_pos);
        pins[2] = int'(sw_inc);

        if (!rst_n || !rst_at_edge) begin
            m_t = 0; m_mode = 0; m_pos = 0; m_phase = 0; m_tick = 0; m_blink = 0;
            for (int b = 0; b < 3; b++) begin
                m_acc[b] = 1;
                m_pulse[b] = 0;
                if (!rst_n) begin
                    for (int k = 0; k < 16; k++) hist[b][k] = 1;
                end
            end
        end else begin
            m_tick = (m_phase == CLK_HZ - 1 && m_pulse[0] == 0) ? 1 : 0;
            if (m_pulse[0] != 0) begin
                if (m_mode == 0) m_pos = 0;
                m_mode = 1 - m_mode;
                m_phase = 0;
            end else begin
                m_phase = (m_phase + 1) % CLK_HZ;
                if (m_mode == 0) begin
                    if (m_tick != 0) m_t = (m_t + 1) % 86400;
                end else begin
                    if (m_pulse[2] != 0) begin
                        s = m_t % 60; mi = (m_t / 60) % 60; h = m_t / 3600;
                        if (m_pos == 0) m_t = m_t - s + (s + 1) % 60;
                        else if (m_pos == 1) m_t = m_t - 60 * mi + 60 * ((mi + 1) % 60);
                        else m_t = m_t - 3600 * h + 3600 * ((h + 1) % 24);
                    end
                    if (m_pulse[1] != 0) m_pos = (m_pos + 1) % 3;
                end
            end
            m_blink = (m_mode == 1 && m_phase < CLK_HZ / 2) ? 1 : 0;
            for (int b = 0; b < 3; b++) begin
                all_diff = 1;
                for (int k = 2; k <= DB + 1; k++) begin
                    if (hist[b][k] == m_acc[b]) all_diff = 0;
                end
                m_pulse[b] = 0;
                if (all_diff != 0) begin
                    m_acc[b] = 1 - m_acc[b];
                    m_pulse[b] = (m_acc[b] == 0) ? 1 : 0;
                end
            end
        end

        if (rst_n) begin
            for (int b = 0; b < 3; b++) begin
                for (int k = 15; k > 0; k--) hist[b][k] = hist[b][k - 1];
                hist[b][0] = pins[b];
            end
        end

        s = m_t % 60; mi = (m_t / 60) % 60; h = m_t / 3600;
        h12 = (h % 12 == 0) ? 12 : h % 12;

        exp_v = {6'(s), 6'(mi), 5'(h), 1'b0, 1'(m_mode), 2'(m_pos), 1'(m_tick), 1'(m_blink)};
        got_v = {a_sec, a_min, a_hour, a_pm, a_mode, a_pos, a_tick, a_blink};
        checkOutput("cycle_h24", 32'(got_v), 32'(exp_v));

        exp_v = {6'(s), 6'(mi), 5'(h12), 1'(h >= 12), 1'(m_mode), 2'(m_pos), 1'(m_tick), 1'(m_blink)};
        got_v = {b_sec, b_min, b_hour, b_pm, b_mode, b_pos, b_tick, b_blink};
        checkOutput("cycle_h12", 32'(got_v), 32'(exp_v));

        if (rec_ticks && a_tick) tick_cycles.push_back(cyc);
    end

    // time limit so the run always ends
    initial begin
        #2_000_000;
        n_fail++;
        $display("[TB] FAIL watchdog: time limit reached, got no end of stimulus, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad, blink_cnt;

        // reset and reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rel_cyc = cyc;
        rec_ticks = 1'b1;
        checkOutput("reset_sec", a_sec, 0);
        checkOutput("reset_hour24", a_hour, 0);
        checkOutput("reset_hour12", b_hour, 12);
        checkOutput("reset_pm12", b_pm, 0);
        checkOutput("reset_mode_pos", {a_mode, a_pos}, 0);
        checkOutput("reset_tick_blink", {a_tick, a_blink}, 0);

        // free run: 60 ticks roll seconds into a minute
        applyStimulus(3'b000, 0, 595);
        checkOutput("run_sec59", a_sec, 59);
        checkOutput("run_min0", a_min, 0);
        applyStimulus(3'b000, 0, 10);
        rec_ticks = 1'b0;
        checkOutput("run_sec0", a_sec, 0);
        checkOutput("run_min1", a_min, 1);
        checkOutput("tick_count", tick_cycles.size(), 60);
        bad = 0;
        for (int i = 1; i < tick_cycles.size(); i++) begin
            if (tick_cycles[i] - tick_cycles[i - 1] != CLK_HZ) bad++;
        end
        checkOutput("tick_period_errors", bad, 0);
        if (tick_cycles.size() > 0) checkOutput("first_tick_offset", tick_cycles[0] - rel_cyc, CLK_HZ);

        // fresh reset, enter SETUP before the first tick, three sec increments
        rst_n = 1'b0;
        applyStimulus(3'b000, 0, 2);
        rst_n = 1'b1;
        applyStimulus(BTN_MODE, 8, 8);
        checkOutput("setup_mode", a_mode, 1);
        checkOutput("setup_pos", a_pos, 0);
        applyStimulus(BTN_INC, 8, 8);
        applyStimulus(BTN_INC, 8, 8);
        sw_inc = 1'b0;
        applyStimulus(3'b000, 0, 6);
        checkOutput("db_cycle6_sec", a_sec, 2);
        applyStimulus(3'b000, 0, 1);
        checkOutput("db_cycle7_sec", a_sec, 3);
        applyStimulus(3'b000, 0, 1);
        sw_inc = 1'b1;
        applyStimulus(3'b000, 0, 8);
        checkOutput("setup_min_kept", a_min, 0);

        blink_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(3'b000, 0, 1);
            blink_cnt += int'(a_blink);
        end
        checkOutput("blink_high_count", blink_cnt, 10);

        // minute field wrap without carry
        applyStimulus(BTN_POS, 8, 8);
        checkOutput("pos_min", a_pos, 1);
        repeat (59) applyStimulus(BTN_INC, 8, 8);
        checkOutput("min_59", a_min, 59);
        applyStimulus(BTN_INC, 8, 8);
        checkOutput("min_wrap", a_min, 0);
        checkOutput("min_wrap_hour", a_hour, 0);

        // set 23:59:59 and let CLOCK mode roll it over
        repeat (59) applyStimulus(BTN_INC, 8, 8);
        applyStimulus(BTN_POS, 8, 8);
        checkOutput("pos_hour", a_pos, 2);
        repeat (23) applyStimulus(BTN_INC, 8, 8);
        applyStimulus(BTN_POS, 8, 8);
        checkOutput("pos_wrap_sec", a_pos, 0);
        repeat (56) applyStimulus(BTN_INC, 8, 8);
        applyStimulus(BTN_MODE, 8, 8);
        checkOutput("pre_roll_h24", {a_hour, a_min, a_sec}, {5'd23, 6'd59, 6'd59});
        checkOutput("pre_roll_h12", {b_hour, b_pm}, {5'd11, 1'b1});
        applyStimulus(3'b000, 0, 1);
        checkOutput("roll_h24", {a_hour, a_min, a_sec}, 0);
        checkOutput("roll_h12", {b_hour, b_pm, b_min, b_sec}, {5'd12, 1'b0, 6'd0, 6'd0});

        // 11:59:59 AM -> 12:00:00 PM
        applyStimulus(BTN_MODE, 8, 8);
        repeat (59) applyStimulus(BTN_INC, 8, 8);
        applyStimulus(BTN_POS, 8, 8);
        repeat (59) applyStimulus(BTN_INC, 8, 8);
        applyStimulus(BTN_POS, 8, 8);
        repeat (11) applyStimulus(BTN_INC, 8, 8);
        applyStimulus(BTN_MODE, 8, 8);
        checkOutput("am_1159_h12", {b_hour, b_pm, b_sec}, {5'd11, 1'b0, 6'd59});
        applyStimulus(3'b000, 0, 1);
        checkOutput("noon_h12", {b_hour, b_pm, b_min, b_sec}, {5'd12, 1'b1, 6'd0, 6'd0});
        checkOutput("noon_h24", a_hour, 12);

        // 12:59:59 PM -> 1:00:00 PM
        applyStimulus(BTN_MODE, 8, 8);
        repeat (59) applyStimulus(BTN_INC, 8, 8);
        applyStimulus(BTN_POS, 8, 8);
        repeat (59) applyStimulus(BTN_INC, 8, 8);
        applyStimulus(BTN_MODE, 8, 8);
        checkOutput("pm_1259_h12", {b_hour, b_pm, b_min, b_sec}, {5'd12, 1'b1, 6'd59, 6'd59});
        applyStimulus(3'b000, 0, 1);
        checkOutput("one_pm_h12", {b_hour, b_pm, b_min, b_sec}, {5'd1, 1'b1, 6'd0, 6'd0});
        checkOutput("one_pm_h24", a_hour, 13);

        // glitch and bounce rejection in SETUP
        applyStimulus(BTN_MODE, 8, 8);
        applyStimulus(BTN_INC, 3, 8);
        checkOutput("glitch_sec", a_sec, 0);
        repeat (4) applyStimulus(BTN_INC, 2, 2);
        applyStimulus(3'b000, 0, 8);
        checkOutput("bounce_sec", a_sec, 0);

        // mode and inc together: mode wins, no increment
        applyStimulus(BTN_MODE | BTN_INC, 8, 8);
        checkOutput("prio_mode", a_mode, 0);
        checkOutput("prio_sec", a_sec, 0);

        // asynchronous reset mid-second while in SETUP
        applyStimulus(BTN_MODE, 8, 8);
        applyStimulus(BTN_INC, 8, 8);
        applyStimulus(BTN_POS, 8, 8);
        applyStimulus(3'b000, 0, 3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_time24", {a_hour, a_min, a_sec}, 0);
        checkOutput("arst_mode_pos", {a_mode, a_pos}, 0);
        checkOutput("arst_blink", a_blink, 0);
        checkOutput("arst_h12", {b_hour, b_pm}, {5'd12, 1'b0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(3'b000, 0, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hms_time_core.md
# hms_time_core

Parametrised single-clock-domain hour:minute:second timekeeping core with button-driven setup mode, for the seven-segment clock designs. All time state advances on clock enables derived from `clk`; no internal signal is used as a clock. It replaces derived-clock min:sec counting with a full H:M:S counter that supports a selectable 12/24-hour format and on-chip debouncing. Its outputs feed the existing binary-to-BCD split, segment decoders and multiplexed display.

## Interface
- `CLK_HZ`, 50_000_000: `clk` frequency; one time tick every `CLK_HZ` cycles (≥ 4).
- `DB_CYCLES`, 500_000: consecutive stable synchronised samples required to accept a button level (≥ 1).
- `H24`, 1: 1 = 24-hour format (0..23); 0 = 12-hour format (1..12) with `o_pm`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_sw_mode` in 1: mode button, active-low, asynchronous to `clk`.
- `i_sw_pos` in 1: field-select button, active-low, asynchronous.
- `i_sw_inc` in 1: increment button, active-low, asynchronous.
- `o_sec` out 6: seconds, 0..59.
- `o_min` out 6: minutes, 0..59.
- `o_hour` out 5: hours, 0..23 or 1..12.
- `o_pm` out 1: PM flag in 12-hour format; constant 0 when `H24`=1.
- `o_mode` out 1: 0 = CLOCK, 1 = SETUP.
- `o_pos` out 2: selected field, 0 = SEC, 1 = MIN, 2 = HOUR; value 3 never occurs.
- `o_tick` out 1: one-cycle pulse per elapsed second, asserted in both modes.
- `o_blink` out 1: blink gate for the selected field; always 0 in CLOCK mode.

## Operation
- **Reset values:** sec = 0, min = 0, hour = 0 (24h) or 12 (12h), `o_pm` = 0, mode = CLOCK, pos = SEC, `o_tick` = 0, `o_blink` = 0, tick counter = 0, debounce states released (high).
- **Button path (each button):**
  - 2-flop synchroniser feeds a stability counter of width `$clog2(DB_CYCLES+1)`.
  - The accepted level changes only after `DB_CYCLES` consecutive synchronised samples differ from it. Any disagreeing sample restarts the count.
  - An accepted high→low transition produces a one-cycle press pulse. Release produces no pulse.
- **Tick counter:**
  - Width `$clog2(CLK_HZ)`; counts 0..`CLK_HZ`-1 and wraps.
  - `o_tick` is asserted (registered) in the cycle after the counter equals `CLK_HZ`-1.
  - Cleared to 0 on every mode change.
- **CLOCK mode:** each tick increments sec.
  - Carry sec 59→0 increments min; min 59→0 increments hour, in the same cycle.
  - 24h: hour 23→0.
  - 12h: hour 12→1; 11→12 toggles `o_pm`.
  - 23:59:59 (24h) or 11:59:59 PM (12h) rolls over to 00:00:00 / 12:00:00 AM.
  - pos and inc presses are ignored.
- **SETUP mode:**
  - Ticks do not change time.
  - A pos press cycles SEC→MIN→HOUR→SEC.
  - An inc press increments only the selected field, with no carry into other fields. Wraps: sec/min 59→0; hour as in CLOCK mode, including the `o_pm` toggle on 11→12.
  - `o_blink` = 1 while tick counter < `CLK_HZ`/2, else 0.
- **Mode press:**
  - Toggles mode and clears the tick counter.
  - Entering SETUP forces pos = SEC.
  - Leaving SETUP keeps the edited time; the first second afterwards is a full `CLK_HZ` cycles.
- **Simultaneous pulses:** mode press has priority; pos/inc pulses in the same cycle are discarded. pos and inc in the same cycle: inc applies to the old pos, then pos advances.
- **Asynchronous reset mid-operation** returns all state to reset values immediately. No press pulse is generated on reset release.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Button pin falls at cycle 0 and is held: press pulse at cycle `DB_CYCLES`+2; the updated field/mode/pos is visible at cycle `DB_CYCLES`+3.
- After reset release or a mode change, `o_tick` first asserts `CLK_HZ` cycles later, then every `CLK_HZ` cycles.
- Time fields update in the same cycle `o_tick` is high.
- Glitches shorter than `DB_CYCLES` cycles produce no pulse.

## Test plan
Use `CLK_HZ`=10 and `DB_CYCLES`=4 unless stated.

- **Reset then free-run, `H24`=1:** 60 ticks (600 cycles) → sec 59→0, min = 1; `o_tick` period exactly 10 cycles.
- **24h rollover:** set 23:59:59 via SETUP, return to CLOCK → after 10 cycles reads 00:00:00 with all fields changing in one cycle.
- **`H24`=0 boundaries:**
  - 11:59:59 AM plus one tick → 12:00:00, `o_pm` = 1.
  - 12:59:59 plus one tick → 1:00:00, `o_pm` unchanged.
- **SETUP edits:**
  - Mode press, then 3 inc presses → sec = 3, min unchanged.
  - pos press, then inc at min = 59 → min = 0, hour unchanged.
  - `o_blink` is high for 5 cycles and low for 5 cycles.
- **Debounce:**
  - 3-cycle low glitch → no change.
  - Held low 8 cycles → exactly one pulse, field updates at cycle 7.
  - Bouncing low/high every 2 cycles → no pulse.
- **Priority and reset:**
  - mode and inc pulses in the same cycle → mode toggles, no increment.
  - `rst_n` asserted mid-second in SETUP → immediately 00:00:00, CLOCK mode, pos = SEC, `o_blink` = 0.
